serial_add_sub: RTL
===================

# serial_add_sub

Parametrised bit-serial adder/subtractor. It reuses a single full-adder cell over `WIDTH` clock cycles to add or subtract two `WIDTH`-bit operands with carry/borrow-in. It sits as a low-area arithmetic unit beside the combinational adder family and is driven through a start/busy/done handshake. Results are held on registered outputs until the next operation completes.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clock`  input  1  rising-edge clock.
- `resetn`  input  1  asynchronous active-low reset.
- `start_in`  input  1  operation request, sampled on a rising edge while idle.
- `mode_in`  input  1  0 = add, 1 = subtract; sampled with `start_in`.
- `a_in`  input  WIDTH  operand A; sampled with `start_in`.
- `b_in`  input  WIDTH  operand B; sampled with `start_in`.
- `c_in`  input  1  carry-in for add, borrow-in for subtract; sampled with `start_in`.
- `sum_out`  output  WIDTH  result of the last completed operation.
- `carry_out`  output  1  carry out of the MSB (for subtract, 1 = no borrow).
- `overflow_out`  output  1  signed overflow of the last completed operation.
- `busy_out`  output  1  high while an operation is in progress.
- `done_out`  output  1  one-cycle pulse marking that the outputs have just updated.

## Operation
- FSM has two states:
  - IDLE → RUN on `start_in`=1.
  - RUN → IDLE when the bit counter reaches `WIDTH`-1.
- On accept (IDLE, `start_in`=1), the block captures:
  - `A` ← `a_in`.
  - `B` ← `b_in` for add, `~b_in` for subtract.
  - carry register ← `c_in` for add, `~c_in` for subtract.
  - bit counter ← 0.
- Subtract therefore computes `a_in - b_in - c_in` mod 2^WIDTH.
- Each RUN cycle processes bit i, LSB first:
  - s = A[i] ^ B[i] ^ cy.
  - cy ← majority(A[i], B[i], cy).
  - s is shifted into an internal result register, which fills from the MSB end.
- Completion, on the edge that processes bit `WIDTH`-1:
  - `sum_out` ← full result.
  - `carry_out` ← final carry.
  - `overflow_out` ← carry into MSB XOR carry out of MSB.
  - `done_out` ← 1.
  - `busy_out` ← 0.
  - state ← IDLE.
- `sum_out`, `carry_out` and `overflow_out` change only at completion or reset. They stay stable for the whole of RUN.
- `start_in` during RUN is ignored; no queueing.
- `mode_in`, `a_in`, `b_in` and `c_in` may change freely after accept.

## Timing
- Reset (`resetn`=0, asynchronous):
  - all outputs 0; state IDLE; counter 0.
  - Applies immediately, including mid-operation. An in-flight operation is discarded and no `done_out` is generated.
- Start accepted at edge k:
  - `busy_out`=1 from after edge k.
  - Bits are processed at edges k+1 … k+`WIDTH`.
  - Results and `done_out`=1 are visible after edge k+`WIDTH`. Latency is `WIDTH` cycles from accept to valid result.
- `done_out` is high for exactly one cycle and clears at edge k+`WIDTH`+1.
- Back-to-back operation:
  - `start_in` held high continuously is next accepted at edge k+`WIDTH`+1.
  - Throughput is one operation per `WIDTH`+1 cycles.
- `busy_out` and `done_out` are never both 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- `WIDTH`=8, add 0x35 + 0x4A, `c_in`=0 → `sum_out`=0x7F, `carry_out`=0, `overflow_out`=0. `done_out` pulses exactly 8 cycles after accept; `busy_out` is high for 8 cycles.
- Add with wrap and overflow:
  - 0xFF + 0x01, `c_in`=0 → 0x00, carry 1, overflow 0.
  - 0x7F + 0x00, `c_in`=1 → 0x80, carry 0, overflow 1.
- Subtract:
  - 0x10 − 0x20, `c_in`=0 → 0xF0, `carry_out`=0 (borrow).
  - 0x80 − 0x01, `c_in`=0 → 0x7F, `carry_out`=1, overflow 1.
- `start_in` held high continuously with new operands each accept:
  - Second accept occurs exactly 9 cycles after the first.
  - Pulses asserted mid-RUN are ignored.
  - `sum_out` stays at its prior value until each completion.
- `resetn` pulsed low 3 cycles after accept:
  - All outputs 0 immediately; no `done_out` follows.
  - A following start completes normally with the correct result.
- `WIDTH`=4, exhaustive: all a, b, `c_in` and both modes (1024 operations) compared against a reference model for sum, carry and overflow.

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell is reused over WIDTH cycles, LSB first,
// behind a start/busy/done handshake with registered result outputs.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start_in,
  input  logic             mode_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] res_q;
  logic [WIDTH-1:0] res_shift;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;
  logic             accept, last, s, cy_next;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_in) state_next = RUN;
      RUN:  if (last)     state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == IDLE) && start_in;
    last      = (state == RUN) && (cnt_q == CW'(WIDTH - 1));
    s         = a_q[0] ^ b_q[0] ^ cy_q;
    cy_next   = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);
    res_shift = {s, res_q};
  end

  assign busy_out = (state == RUN);

  // Operands shift right so the active bit is always at position 0; the
  // result fills from the MSB end and is complete on the final shift.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      cy_q         <= 1'b0;
      sum_out      <= '0;
      carry_out    <= 1'b0;
      overflow_out <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (accept) begin
        a_q   <= a_in;
        b_q   <= mode_in ? ~b_in : b_in;
        cy_q  <= mode_in ? ~c_in : c_in;
        cnt_q <= '0;
      end else if (state == RUN) begin
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        cy_q  <= cy_next;
        res_q <= res_shift[WIDTH-1:1];
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          sum_out      <= res_shift;
          carry_out    <= cy_next;
          overflow_out <= cy_q ^ cy_next;
          done_out     <= 1'b1;
        end
      end
    end
  end

endmodule
